instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch sequencer for the 8-bit CPU. Reads one instruction byte from program memory at the current program counter through a read/ready handshake, then presents it to the instruction register with a single-cycle load strobe and advances the PC. It sits between program memory and the instruction register, and is driven by the control unit through `fetch_req`, `pc_load` and `pc_in`.

## Interface
- `WIDTH_ADDRESS_BIT`, default 5: PC and memory address width.
- `WIDTH_REG`, default 8: instruction word width.
- `OPCODE`, default 3: opcode field width, which is `ir_data[WIDTH_REG-1 -: OPCODE]`.

Ports:
- `clk`  in  1  rising-edge clock (single clock domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  request one instruction fetch; sampled in IDLE only.
- `pc_load`  in  1  load `pc_in` as the next fetch address.
- `pc_in`  in  WIDTH_ADDRESS_BIT  jump target.
- `mem_addr`  out  WIDTH_ADDRESS_BIT  program memory address.
- `mem_rd`  out  1  memory read request.
- `mem_data`  in  WIDTH_REG  memory read data; valid when `mem_ready`=1.
- `mem_ready`  in  1  memory data valid.
- `ir_load`  out  1  one-cycle load strobe to the instruction register.
- `ir_data`  out  WIDTH_REG  instruction byte for the instruction register.
- `pc`  out  WIDTH_ADDRESS_BIT  current program counter.
- `busy`  out  1  high in any state other than IDLE.
- `halted`  out  1  halt state flag; tied to 0 when the halt feature is compiled out.

## Operation
- States: IDLE, REQ, WAIT, LOAD, HALTED. All outputs are decoded from registered state, so they are glitch-free.
- IDLE:
  - If `pc_load`=1, then `pc` <= `pc_in` and the FSM stays in IDLE. `pc_load` has priority: a `fetch_req` in the same cycle is dropped.
  - Otherwise, if `fetch_req`=1, go to REQ.
- REQ: `mem_rd`=1 and `mem_addr`=`pc`. Go to WAIT unconditionally. `mem_ready` is ignored in this state.
- WAIT: `mem_rd`=1 and `mem_addr`=`pc`. Hold until `mem_ready`=1. On that edge, `ir_data` <= `mem_data`, then go to LOAD. There is no timeout; the FSM waits indefinitely.
- LOAD: `ir_load`=1 for exactly one cycle and `mem_rd`=0. The PC update and next state are:
  - If a jump is pending, `pc` <= pending target.
  - Otherwise, `pc` <= `pc`+1, modulo 2^WIDTH_ADDRESS_BIT (so 31 wraps to 0).
  - Next state is IDLE, or HALTED per Configuration.
- A `pc_load` during REQ, WAIT or LOAD sets a pending flag and captures `pc_in`. The last one seen wins. The pending target is applied at the LOAD edge and the flag is then cleared. The in-flight fetch still uses the old address.
- `ir_data` holds its value outside the WAIT-to-LOAD capture edge.
- `mem_addr` equals `pc` in all states.

## Timing
- Reset values: state=IDLE, `pc`=0, `ir_data`=0, `mem_rd`=0, `ir_load`=0, `busy`=0, `halted`=0, pending flag=0.
- Asynchronous assertion of `reset_n` mid-fetch aborts immediately. Any `ir_load` in progress is lost.
- Fetch latency is counted from the edge that samples `fetch_req` (edge 0):
  - REQ in cycle 1, WAIT from cycle 2.
  - With `mem_ready`=1 in the first WAIT cycle, `ir_load`=1 in cycle 3 and the new `pc` is visible in cycle 4.
  - Each extra wait cycle adds 1.
- Back-to-back fetches: `fetch_req` held high gives one fetch per 4 cycles when memory responds immediately. IDLE is always visited for one cycle between fetches.
- `ir_data` is stable and valid in the cycle where `ir_load`=1.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - In LOAD, if the fetched opcode field is all zeros (HLT), the FSM goes to HALTED instead of IDLE. `ir_load` still pulses and `pc` still advances.
  - In HALTED, `halted`=1 and `busy`=1. `fetch_req` and `pc_load` are ignored. Only `reset_n` exits.
- Not defined: the HALTED state is not compiled, `halted` is tied to 0, and opcode 0 fetches like any other instruction.

## Test plan
- Reset then single fetch: mem[0]=8'hA5, `mem_ready` given in the first WAIT cycle. Required: `ir_load` in cycle 3 with `ir_data`=8'hA5, then `pc`=1.
- Slow memory: `mem_ready` delayed 3 cycles. Required: `mem_rd` stays high through WAIT, `ir_load` in cycle 6, and exactly one pulse.
- Wrap: `pc_load` with `pc_in`=31 in IDLE, then fetch. Required: `mem_addr`=31 and `pc`=0 after LOAD. A `fetch_req` in the same cycle as `pc_load` is dropped (`busy` stays 0).
- Jump during WAIT: start a fetch at `pc`=4 and pulse `pc_load` with `pc_in`=17 in WAIT. Required: the fetch reads addr 4 and `pc`=17 after LOAD.
- Reset mid-WAIT: drop `reset_n` during WAIT. Required: `mem_rd`, `ir_load` and `busy` go to 0 immediately, `pc`=0, and no `ir_load` after release.
- `FETCH_HALT_DETECT_EN`: mem[2]=8'h1F fetched. Required: `halted`=1 and `pc`=3, and further `fetch_req` produces no `mem_rd`. Without the macro, the same fetch returns to IDLE with `halted`=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: PC -> program memory read/ready handshake -> IR load strobe.
// Optional halt detection (opcode 0 parks the FSM in HALTED) is compiled in with FETCH_HALT_DETECT_EN.
module instr_fetch_unit #(
    parameter int WIDTH_ADDRESS_BIT = 5,
    parameter int WIDTH_REG         = 8,
    parameter int OPCODE            = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_req,
    input  logic                         pc_load,
    input  logic [WIDTH_ADDRESS_BIT-1:0] pc_in,
    output logic [WIDTH_ADDRESS_BIT-1:0] mem_addr,
    output logic                         mem_rd,
    input  logic [WIDTH_REG-1:0]         mem_data,
    input  logic                         mem_ready,
    output logic                         ir_load,
    output logic [WIDTH_REG-1:0]         ir_data,
    output logic [WIDTH_ADDRESS_BIT-1:0] pc,
    output logic                         busy,
    output logic                         halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD
`ifdef FETCH_HALT_DETECT_EN
        , S_HALTED
`endif
    } state_t;

    state_t                       state_q, state_d;
    logic [WIDTH_ADDRESS_BIT-1:0] pc_q, pc_d;
    logic [WIDTH_REG-1:0]         ir_q, ir_d;
    logic                         pend_q, pend_d;
    logic [WIDTH_ADDRESS_BIT-1:0] pend_addr_q, pend_addr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (fetch_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                if (pc_load) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pc_in;
                end
            end
            S_WAIT: begin
                if (pc_load) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pc_in;
                end
                if (mem_ready) begin
                    ir_d    = mem_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A jump arriving in LOAD itself is the most recent one, so it beats the pending target.
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (pend_q) begin
                    pc_d = pend_addr_q;
                end else begin
                    pc_d = pc_q + WIDTH_ADDRESS_BIT'(1);
                end
                pend_d  = 1'b0;
                state_d = S_IDLE;
`ifdef FETCH_HALT_DETECT_EN
                if (ir_q[WIDTH_REG-1 -: OPCODE] == '0) begin
                    state_d = S_HALTED;
                end
`endif
            end
`ifdef FETCH_HALT_DETECT_EN
            S_HALTED: begin
                state_d = S_HALTED;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir_data  = ir_q;
    assign mem_rd   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign ir_load  = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
`ifdef FETCH_HALT_DETECT_EN
    assign halted   = (state_q == S_HALTED);
`else
    assign halted   = 1'b0;
`endif

endmodule
